tft_frame_sequencer: RTL
========================

# tft_frame_sequencer

Sequences one full-screen redraw on the shared TFT byte channel. Once the panel reports init done, each frame request issues the address-window and memory-write commands with the proper D/C level. It then hands the byte channel to the pixel source (the scene drawer) and returns to idle when that source drains. It sits between the pixel source and the SPI byte transmitter, and owns `tft_dc` after init.

## Interface
- `SCREEN_W`, default 320: columns; CASET end = `SCREEN_W-1`.
- `SCREEN_H`, default 480: rows; PASET end = `SCREEN_H-1`.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `init_done`, in, 1: panel init sequence finished (level).
- `frame_req`, in, 1: redraw request; a single-cycle pulse is sufficient.
- `tft_busy`, in, 1: byte transmitter busy; rises the cycle after an accepted `tft_transmit`.
- `pix_data`, in, 8: pixel byte from the pixel source.
- `pix_transmit`, in, 1: pixel source byte strobe.
- `pix_busy`, in, 1: pixel source still has bytes to send.
- `pix_start`, out, 1: one-cycle pulse; the pixel source rewinds to the first pixel.
- `pix_enable`, out, 1: the pixel source may run.
- `tft_data`, out, 8: byte to the transmitter.
- `tft_transmit`, out, 1: byte strobe to the transmitter.
- `tft_dc`, out, 1: 0 = command, 1 = data.
- `frame_busy`, out, 1: high in every state except IDLE.
- `frame_done`, out, 1: one-cycle pulse when a frame completes.

## Operation
- States and transitions:
  - IDLE -> CMD_SEND when `pending & init_done & ~tft_busy`.
  - CMD_SEND: exactly one cycle. `tft_transmit`=1, `tft_data`=`rom[idx]`, `tft_dc`=`dc[idx]`. Always -> CMD_WAIT.
  - CMD_WAIT: `tft_transmit`=0; `tft_dc` and `tft_data` hold. The first cycle is a guard cycle. After that, when `tft_busy`=0: if `idx` is the last entry -> PIX_START, else increment `idx` -> CMD_SEND.
  - PIX_START: one cycle, `pix_start`=1 -> PIXELS.
  - PIXELS: `pix_enable`=1, `tft_dc`=1. `tft_data`/`tft_transmit` are combinational pass-throughs of `pix_data`/`pix_transmit`. The state is left when `pix_busy`=0, `pix_transmit`=0 and `tft_busy`=0, all in the same cycle, and not in the first PIXELS cycle.
  - FINISH: `frame_done`=1 for one cycle -> IDLE.
- Command ROM (with window enabled), 11 entries; D/C shown after the slash:
  - 2A/0, 00/1, 00/1, `(SCREEN_W-1)>>8`/1, `(SCREEN_W-1)&FF`/1
  - 2B/0, 00/1, 00/1, `(SCREEN_H-1)>>8`/1, `(SCREEN_H-1)&FF`/1
  - 2C/0
  - Defaults give 2A 00 00 01 3F 2B 00 00 01 DF 2C.
- Request handling:
  - `frame_req` sets `pending` on any cycle. `pending` clears on the IDLE -> CMD_SEND transition.
  - A request arriving during a frame sets `pending`, so exactly one further frame follows. Multiple requests coalesce.
  - A request is held while `init_done`=0.
  - `frame_req` and a clear in the same cycle: the set wins.
- Abort: `init_done` falling in any non-IDLE state -> IDLE next cycle. No `frame_done`; `pending` cleared; `idx`=0; `pix_enable` drops.
- Outside PIXELS, `pix_data`/`pix_transmit` are ignored.

## Timing
- Reset values:
  - `tft_data`=00, `tft_transmit`=0, `tft_dc`=0.
  - `pix_start`=0, `pix_enable`=0.
  - `frame_busy`=0, `frame_done`=0.
  - State IDLE, `idx`=0, `pending`=0.
- `rst_n` low mid-frame clears everything immediately (asynchronously). The next frame starts from command 0.
- A `frame_req` pulse at cycle t sets `pending` at t+1. CMD_SEND follows at t+2 if `init_done` and `tft_busy`=0.
- Per command byte: at least 2 cycles (SEND + guard), stretched by `tft_busy`.
- `tft_transmit` is never high on two consecutive cycles in the command phase.
- `frame_done` is asserted the cycle after the PIXELS exit condition holds.
- `frame_busy` drops the cycle after `frame_done`.

## Configuration
- `TFT_FRAME_SEQ_WINDOW_EN` defined: the full 11-byte ROM, so CASET/PASET are re-sent every frame.
- Not defined: the ROM is the single entry 2C/0, relying on the window set by init. The last index is 0, and the `SCREEN_W`/`SCREEN_H` parameters are unused.

## Test plan
- Window on, `init_done`=1, idle transmitter (busy 4 cycles/byte), `frame_req` pulse -> bytes 2A 00 00 01 3F 2B 00 00 01 DF 2C with `tft_dc` 0,1,1,1,1,0,1,1,1,1,0; then `pix_start` pulse; `pix_enable` high.
- Pixel stub with 12 bytes of AA, `pix_busy` falling after the last byte -> 12 AA bytes with `tft_dc`=1; `frame_done` pulses once; `frame_busy`=0 one cycle later.
- `frame_req` while `init_done`=0, `init_done` raised 50 cycles later -> first 2A issued 1 cycle after `init_done` rises.
- Three `frame_req` pulses during a frame -> exactly two frames total, two `frame_done` pulses.
- `init_done` dropped at the 5th command byte -> IDLE next cycle, no `frame_done`; the next frame starts from 2A. `rst_n` low during PIXELS -> all outputs at reset values within the same cycle.
- Window off -> a single 2C with `tft_dc`=0, then `pix_start`.

Source files
------------

// File: rtl/tft_frame_sequencer.sv
// Frame redraw sequencer: issues window/RAMWR commands, then hands the byte channel to the pixel source.
// Define TFT_FRAME_SEQ_WINDOW_EN to re-send CASET/PASET every frame (default: RAMWR only).
module tft_frame_sequencer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       frame_req,
  input  logic       tft_busy,
  input  logic [7:0] pix_data,
  input  logic       pix_transmit,
  input  logic       pix_busy,
  output logic       pix_start,
  output logic       pix_enable,
  output logic [7:0] tft_data,
  output logic       tft_transmit,
  output logic       tft_dc,
  output logic       frame_busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, CMD_SEND, CMD_WAIT, PIX_START, PIXELS, FINISH
  } state_e;

  localparam logic [15:0] W_END = 16'(SCREEN_W - 1);
  localparam logic [15:0] H_END = 16'(SCREEN_H - 1);

  // Window-off reuses the table tail so idx still counts from 0.
`ifdef TFT_FRAME_SEQ_WINDOW_EN
  localparam logic [3:0] ROM_BASE = 4'd0;
  localparam logic [3:0] LAST_IDX = 4'd10;
`else
  localparam logic [3:0] ROM_BASE = 4'd10;
  localparam logic [3:0] LAST_IDX = 4'd0;
`endif

  function automatic logic [8:0] rom_entry(input logic [3:0] i);
    case (i)
      4'd0:       rom_entry = {1'b0, 8'h2A};
      4'd1, 4'd2: rom_entry = {1'b1, 8'h00};
      4'd3:       rom_entry = {1'b1, W_END[15:8]};
      4'd4:       rom_entry = {1'b1, W_END[7:0]};
      4'd5:       rom_entry = {1'b0, 8'h2B};
      4'd6, 4'd7: rom_entry = {1'b1, 8'h00};
      4'd8:       rom_entry = {1'b1, H_END[15:8]};
      4'd9:       rom_entry = {1'b1, H_END[7:0]};
      default:    rom_entry = {1'b0, 8'h2C};
    endcase
  endfunction

  state_e     state_q;
  logic [3:0] idx_q;
  logic       pending_q;
  logic       pending_d;
  logic       first_q;
  logic [7:0] data_q;
  logic       tx_q;
  logic       dc_q;
  logic       start_q;
  logic       en_q;
  logic       done_q;

  logic       go;
  logic       abort;
  logic       last;
  logic       pix_exit;
  logic [8:0] nxt_entry;
  logic       in_pix;

  always_comb begin
    go        = (state_q == IDLE) && pending_q && init_done && !tft_busy;
    abort     = (state_q != IDLE) && !init_done;
    pending_d = frame_req | (pending_q & ~(go | abort));
    last      = (idx_q == LAST_IDX);
    nxt_entry = rom_entry(ROM_BASE + idx_q + 4'd1);
    pix_exit  = !first_q && !pix_busy && !pix_transmit && !tft_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      first_q   <= 1'b0;
      data_q    <= '0;
      tx_q      <= 1'b0;
      dc_q      <= 1'b0;
      start_q   <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (abort) begin
        state_q <= IDLE;
        idx_q   <= '0;
        tx_q    <= 1'b0;
        start_q <= 1'b0;
        en_q    <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (go) begin
              state_q          <= CMD_SEND;
              idx_q            <= '0;
              tx_q             <= 1'b1;
              {dc_q, data_q}   <= rom_entry(ROM_BASE);
            end
          end
          CMD_SEND: begin
            tx_q    <= 1'b0;
            first_q <= 1'b1;
            state_q <= CMD_WAIT;
          end
          CMD_WAIT: begin
            // first cycle is a guard: tft_busy only rises now
            first_q <= 1'b0;
            if (!first_q && !tft_busy) begin
              if (last) begin
                start_q <= 1'b1;
                state_q <= PIX_START;
              end else begin
                idx_q          <= idx_q + 4'd1;
                tx_q           <= 1'b1;
                {dc_q, data_q} <= nxt_entry;
                state_q        <= CMD_SEND;
              end
            end
          end
          PIX_START: begin
            start_q <= 1'b0;
            en_q    <= 1'b1;
            dc_q    <= 1'b1;
            first_q <= 1'b1;
            state_q <= PIXELS;
          end
          PIXELS: begin
            first_q <= 1'b0;
            if (pix_exit) begin
              en_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
          FINISH: begin
            done_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_pix       = (state_q == PIXELS);
  assign tft_data     = in_pix ? pix_data : data_q;
  assign tft_transmit = in_pix ? pix_transmit : tx_q;
  assign tft_dc       = dc_q;
  assign pix_start    = start_q;
  assign pix_enable   = en_q;
  assign frame_busy   = (state_q != IDLE);
  assign frame_done   = done_q;

endmodule
